// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM encoding, RV32 width codes,
// exception causes and the held request/response records.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] CAUSE_NONE   = 4'd0;
  localparam logic [3:0] CAUSE_LD_MIS = 4'd4;
  localparam logic [3:0] CAUSE_LD_ACC = 4'd5;
  localparam logic [3:0] CAUSE_ST_MIS = 4'd6;
  localparam logic [3:0] CAUSE_ST_ACC = 4'd7;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } lsu_req_t;

  typedef struct packed {
    logic        exc;
    logic [3:0]  cause;
    logic [31:0] rdata;
  } lsu_resp_t;

  function automatic logic [3:0] mis_cause(input logic we);
    return we ? CAUSE_ST_MIS : CAUSE_LD_MIS;
  endfunction

  function automatic logic [3:0] acc_cause(input logic we);
    return we ? CAUSE_ST_ACC : CAUSE_LD_ACC;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response channel and memory-responder channel of the LSU.
interface lsu_core_if;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_exc;
  logic [31:0] resp_rdata;
  logic [3:0]  resp_cause;

  modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
                  input  req_ready, resp_valid, resp_rdata, resp_exc, resp_cause);
  modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
                  output req_ready, resp_valid, resp_rdata, resp_exc, resp_cause);
endinterface

interface lsu_mem_if #(parameter int MEM_AW = 16);
  logic              mem_en, mem_wr, mem_exception;
  logic [MEM_AW-1:0] mem_addr;
  logic [2:0]        mem_size;
  logic [31:0]       mem_wdata, mem_rdata;

  modport master (output mem_en, mem_wr, mem_addr, mem_size, mem_wdata,
                  input  mem_rdata, mem_exception);
  modport slave  (input  mem_en, mem_wr, mem_addr, mem_size, mem_wdata,
                  output mem_rdata, mem_exception);
endinterface

// File: rtl/lsu_addr_check.sv
// Acceptance-time classification: window/width access faults beat misalignment.
module lsu_addr_check
  import lsu_pkg::*;
#(
  parameter int          MEM_AW   = 16,
  parameter logic [31:0] MEM_BASE = 32'h0000_0000
) (
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output logic        fault,
  output logic [3:0]  cause
);
  logic out_win, bad_f3, misal;

  always_comb begin
    out_win = addr[31:MEM_AW] != MEM_BASE[31:MEM_AW];
    bad_f3  = (funct3 inside {3'b011, 3'b110, 3'b111}) ||
              (we && (funct3 inside {F3_BU, F3_HU}));
    misal   = ((funct3 inside {F3_H, F3_HU}) && addr[0]) ||
              ((funct3 == F3_W) && (addr[1:0] != 2'b00));
    fault   = 1'b0;
    cause   = CAUSE_NONE;
    if (out_win || bad_f3) begin
      fault = 1'b1;
      cause = acc_cause(we);
    end else if (misal) begin
      fault = 1'b1;
      cause = mis_cause(we);
    end
  end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32 load/store unit: classify, issue one memory beat,
// capture the formatted load data and hold the response until consumed.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int          MEM_AW   = 16,
  parameter logic [31:0] MEM_BASE = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  lsu_core_if.slave   core,
  lsu_mem_if.master   mem
);
  lsu_state_e        state_q, state_d;
  lsu_req_t          req_q;
  logic [MEM_AW-1:0] addr_q;
  lsu_resp_t         resp_q;
  logic              chk_fault;
  logic [3:0]        chk_cause;

  lsu_addr_check #(.MEM_AW(MEM_AW), .MEM_BASE(MEM_BASE)) u_chk (
    .we(core.req_we), .funct3(core.req_funct3), .addr(core.req_addr),
    .fault(chk_fault), .cause(chk_cause)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (core.req_valid) state_d = chk_fault ? DONE : ISSUE;
      ISSUE:   state_d = req_q.we ? DONE : WAIT;
      WAIT:    state_d = DONE;
      DONE:    if (core.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (core.req_valid) begin
          req_q  <= '{we: core.req_we, funct3: core.req_funct3, wdata: core.req_wdata};
          addr_q <= core.req_addr[MEM_AW-1:0];
          resp_q <= '{exc: chk_fault, cause: chk_cause, rdata: 32'h0};
        end
        // Responder-reported errors surface as misalignment for the access direction
        ISSUE: if (mem.mem_exception) begin
          resp_q.exc   <= 1'b1;
          resp_q.cause <= mis_cause(req_q.we);
        end
        WAIT: if (!resp_q.exc) resp_q.rdata <= mem.mem_rdata;
        default: ;
      endcase
    end
  end

  // Strobes decode straight from the state register so reset kills them at once
  assign mem.mem_en    = (state_q == ISSUE);
  assign mem.mem_wr    = (state_q == ISSUE) && req_q.we;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_size  = req_q.funct3;
  assign mem.mem_wdata = req_q.wdata;

  assign core.req_ready  = (state_q == IDLE);
  assign core.resp_valid = (state_q == DONE);
  assign core.resp_exc   = resp_q.exc;
  assign core.resp_cause = resp_q.cause;
  assign core.resp_rdata = resp_q.rdata;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus random transactions against a byte-array reference model.
module tb_load_store_unit;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  lsu_core_if core();
  lsu_mem_if #(.MEM_AW(16)) mem();

  load_store_unit #(.MEM_AW(16), .MEM_BASE(32'h0000_0000)) dut (
    .CLK(CLK), .RST_N(RST_N), .core(core), .mem(mem)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit [7:0] dmem    [65536];
  bit [7:0] ref_mem [65536];
  logic inject = 1'b0;
  int en_cnt = 0;
  int wr_cnt = 0;

  // Memory responder: little-endian bytes, formats loads from addr/size
  always @(negedge CLK) begin
    logic [31:0] v;
    int n;
    n = (mem.mem_size[1:0] == 2'd0) ? 1 : (mem.mem_size[1:0] == 2'd1) ? 2 : 4;
    v = 32'h0;
    for (int i = 0; i < 4; i++)
      if (i < n) v[8*i +: 8] = dmem[mem.mem_addr + 16'(i)];
    if (!mem.mem_size[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!mem.mem_size[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
    mem.mem_rdata     <= v;
    mem.mem_exception <= inject && mem.mem_en;
  end

  always @(posedge CLK) begin
    if (mem.mem_en) en_cnt <= en_cnt + 1;
    if (mem.mem_wr) begin
      wr_cnt <= wr_cnt + 1;
      if (!inject)
        for (int i = 0; i < 4; i++)
          if (i < ((mem.mem_size[1:0] == 2'd0) ? 1 : (mem.mem_size[1:0] == 2'd1) ? 2 : 4))
            dmem[mem.mem_addr + 16'(i)] <= mem.mem_wdata[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RV32 rules applied to a flat byte array
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic inj,
                                output logic exc, output logic [3:0] cause,
                                output logic [31:0] rd, output int lat, output bit mem_touch);
    int n;
    exc = 0; cause = 0; rd = 0; mem_touch = 0;
    n = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
    if (a[31:16] != 0 || f3 == 3 || f3 >= 6 || (we && f3 >= 4)) begin
      exc = 1; cause = we ? 7 : 5; lat = 1; return;
    end
    if (a % n != 0) begin
      exc = 1; cause = we ? 6 : 4; lat = 1; return;
    end
    mem_touch = 1;
    lat = we ? 2 : 3;
    if (inj) begin
      exc = 1; cause = we ? 6 : 4; return;
    end
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[a[15:0] + 16'(i)] = wd[8*i +: 8];
    end else begin
      longint unsigned u = 0;
      for (int i = 0; i < n; i++) u += longint'(ref_mem[a[15:0] + 16'(i)]) << (8*i);
      if (f3[2] == 0 && n < 4 && u >= (longint'(1) << (8*n - 1))) u += 64'h1_0000_0000 - (longint'(1) << (8*n));
      rd = u[31:0];
    end
  endfunction

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int hold, input string tag);
    logic e_exc; logic [3:0] e_cause; logic [31:0] e_rd; int e_lat; bit touch;
    int lat, en0, wr0;
    logic [31:0] rd0;
    model(we, f3, a, wd, inject, e_exc, e_cause, e_rd, e_lat, touch);
    en0 = en_cnt; wr0 = wr_cnt;
    chk({tag, ".req_ready"}, 32'(core.req_ready), 32'd1);
    core.req_valid = 1; core.req_we = we; core.req_funct3 = f3;
    core.req_addr = a; core.req_wdata = wd;
    @(posedge CLK); #1;
    core.req_valid = 0;
    lat = 0;
    while (lat < 8) begin
      @(negedge CLK);
      lat++;
      if (core.resp_valid) break;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(e_lat));
    chk({tag, ".exc"}, 32'(core.resp_exc), 32'(e_exc));
    chk({tag, ".cause"}, 32'(core.resp_cause), 32'(e_cause));
    chk({tag, ".rdata"}, core.resp_rdata, e_rd);
    rd0 = core.resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk({tag, ".hold_valid"}, 32'(core.resp_valid), 32'd1);
      chk({tag, ".hold_ready"}, 32'(core.req_ready), 32'd0);
      chk({tag, ".hold_rdata"}, core.resp_rdata, rd0);
      chk({tag, ".hold_cause"}, 32'(core.resp_cause), 32'(e_cause));
    end
    core.resp_ready = 1;
    @(posedge CLK); #1;
    core.resp_ready = 0;
    @(negedge CLK);
    chk({tag, ".mem_en_pulses"}, 32'(en_cnt - en0), touch ? 32'd1 : 32'd0);
    chk({tag, ".mem_wr_pulses"}, 32'(wr_cnt - wr0), (touch && we) ? 32'd1 : 32'd0);
    chk({tag, ".idle_after"}, 32'(core.req_ready), 32'd1);
  endtask

  // Reset asserted after 'edges' clock edges of an in-flight request
  task automatic reset_mid(input logic we, input logic [31:0] a, input int edges, input string tag);
    core.req_valid = 1; core.req_we = we; core.req_funct3 = 3'b010;
    core.req_addr = a; core.req_wdata = 32'hCAFE_F00D;
    @(posedge CLK); #1;
    core.req_valid = 0;
    if (edges == 2) begin @(posedge CLK); #1; end
    chk({tag, ".en_before"}, 32'(mem.mem_en), (edges == 1) ? 32'd1 : 32'd0);
    RST_N = 0;
    #1;
    chk({tag, ".en_async"}, 32'(mem.mem_en), 32'd0);
    chk({tag, ".wr_async"}, 32'(mem.mem_wr), 32'd0);
    chk({tag, ".ready_async"}, 32'(core.req_ready), 32'd1);
    @(negedge CLK);
    RST_N = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk({tag, ".no_resp"}, 32'(core.resp_valid), 32'd0);
      chk({tag, ".idle"}, 32'(core.req_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    core.req_valid = 0; core.req_we = 0; core.req_funct3 = 0;
    core.req_addr = 0; core.req_wdata = 0; core.resp_ready = 0;
    #12;
    chk("rst.req_ready", 32'(core.req_ready), 32'd1);
    chk("rst.resp_valid", 32'(core.resp_valid), 32'd0);
    chk("rst.resp_exc", 32'(core.resp_exc), 32'd0);
    chk("rst.resp_cause", 32'(core.resp_cause), 32'd0);
    chk("rst.resp_rdata", core.resp_rdata, 32'd0);
    chk("rst.mem_en", 32'(mem.mem_en), 32'd0);
    chk("rst.mem_wr", 32'(mem.mem_wr), 32'd0);
    chk("rst.mem_addr", 32'(mem.mem_addr), 32'd0);
    chk("rst.mem_size", 32'(mem.mem_size), 32'd0);
    chk("rst.mem_wdata", mem.mem_wdata, 32'd0);
    @(negedge CLK);
    RST_N = 1;
    @(negedge CLK);

    txn(1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 0, "sw_10");
    txn(0, 3'b010, 32'h0000_0010, 32'h0, 0, "lw_10");
    txn(1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 0, "sb_13");
    txn(0, 3'b000, 32'h0000_0013, 32'h0, 0, "lb_13");
    txn(0, 3'b100, 32'h0000_0013, 32'h0, 0, "lbu_13");
    txn(0, 3'b010, 32'h0000_0002, 32'h0, 0, "lw_mis");
    txn(1, 3'b001, 32'h0001_0000, 32'h1234, 0, "sh_oow");
    txn(0, 3'b001, 32'h0000_0012, 32'h0, 5, "lh_hold");
    txn(1, 3'b100, 32'h0000_0020, 32'h77, 0, "sbu_bad");
    txn(0, 3'b011, 32'h0000_0020, 32'h0, 0, "ld_f3_011");
    txn(1, 3'b010, 32'h0000_0021, 32'h1, 0, "sw_mis");
    inject = 1;
    txn(0, 3'b010, 32'h0000_0010, 32'h0, 0, "lw_inj");
    txn(1, 3'b010, 32'h0000_0010, 32'h1111_2222, 0, "sw_inj");
    inject = 0;
    txn(0, 3'b010, 32'h0000_0010, 32'h0, 0, "lw_after_inj");

    reset_mid(0, 32'h0000_0010, 2, "rst_wait");
    reset_mid(1, 32'h0000_0040, 1, "rst_issue");
    txn(0, 3'b010, 32'h0000_0040, 32'h0, 0, "lw_40_untouched");

    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(16, 31));
      inject = ($urandom_range(0, 15) == 0);
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
          int'($urandom_range(0, 2)), $sformatf("rnd%0d", k));
    end
    inject = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_AW, default 16, meaning the memory byte-address width driven on mem_addr.
REQ-002 SHALL have parameter MEM_BASE, default 32'h0000_0000, meaning the base of the memory window; bits [31:MEM_AW] select the window.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port RST_N  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  core presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  LSU accepts the request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  response available.
REQ-012 SHALL have port resp_ready  input  1  core consumes the response.
REQ-013 SHALL have port resp_rdata  output  32  load result, already extended; 0 for stores and faults.
REQ-014 SHALL have port resp_exc  output  1  the access faulted.
REQ-015 SHALL have port resp_cause  output  4  4 load-misaligned, 5 load-access, 6 store-misaligned, 7 store-access; 0 when resp_exc=0.
REQ-016 SHALL have ports mem_en/mem_wr (output, 1), mem_addr (output, MEM_AW), mem_size (output, 3), mem_wdata (output, 32), mem_rdata (input, 32) and mem_exception (input, 1), all connecting to the memory responder.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; req_ready=1 only in IDLE.
REQ-018 SHALL latch we, funct3, addr and wdata on IDLE && req_valid; held registers alone drive all mem_* outputs.
REQ-019 SHALL classify at acceptance: access fault if addr[31:MEM_AW] != MEM_BASE[31:MEM_AW] or funct3 is 011/110/111, or store with funct3 100/101; misaligned if H/HU with addr[0]=1 or W with addr[1:0]!=0; access fault takes priority.
REQ-020 SHALL, on fault, go IDLE->DONE with resp_exc=1 and the REQ-015 cause, never asserting mem_en.
REQ-021 SHALL, in ISSUE, drive mem_en=1, mem_wr=we, mem_addr=addr[MEM_AW-1:0], mem_size=funct3, mem_wdata=wdata; store -> DONE, load -> WAIT.
REQ-022 SHALL, in WAIT, drive mem_en=0 and mem_wr=0 while holding mem_addr/mem_size stable, and capture mem_rdata into resp_rdata (the responder formats combinationally from addr/size).
REQ-023 SHALL sample mem_exception in ISSUE; if it is 1, the response SHALL carry resp_exc=1 with the misaligned cause for that direction.
REQ-024 SHALL hold resp_valid and all resp_* stable in DONE until resp_ready=1, then return to IDLE; resp_valid && resp_ready in the same cycle takes one cycle.
REQ-025 SHALL provide latency from acceptance edge to resp_valid of 3 cycles for loads, 2 for stores and 1 for faults; back-to-back issue occurs the cycle after the handshake.
REQ-026 SHALL keep mem_en=0 and mem_wr=0 in IDLE, WAIT and DONE; mem_wr never asserts without mem_en.

Reset
REQ-027 SHALL force, on RST_N low: state=IDLE, req_ready=1, resp_valid=0, resp_exc=0, resp_cause=0, resp_rdata=0, mem_en=0, mem_wr=0, mem_addr=0, mem_size=0, mem_wdata=0.
REQ-028 SHALL abandon any in-flight request on reset mid-operation without a response, and deassert mem_en/mem_wr immediately (asynchronously).

Structure
REQ-029 SHALL define the FSM state encoding, funct3 width codes and exception cause codes in a shared package, lsu_pkg.
REQ-030 SHALL place the alignment/range classification in one combinational sub-module, lsu_addr_check.

Verification
REQ-031 SHALL test: LW addr 0x0000_0010 after SW 0xDEADBEEF there -> store resp at +2 cycles with mem_wr pulsed once; load resp_rdata=0xDEADBEEF at +3 cycles.
REQ-032 SHALL test: SB 0xA5 to 0x0000_0013, then LB 0x13 and LBU 0x13 -> resp_rdata 0xFFFFFFA5 and 0x000000A5.
REQ-033 SHALL test: LW addr 0x0000_0002 -> resp_exc=1, cause 4, at +1 cycle, mem_en never asserted.
REQ-034 SHALL test: SH addr 0x0001_0000 -> resp_exc=1, cause 7, no memory write.
REQ-035 SHALL test: resp_ready held 0 for 5 cycles -> resp_* stable and req_ready=0 throughout.
REQ-036 SHALL test: RST_N low during WAIT -> same-cycle mem_en=0; after release IDLE, no resp_valid.
